// File: rtl/mem_apb_ws.sv
// -----------------------------------------------------------------------------
// mem_apb_ws -- parametrised APB4 memory slave with programmable wait states.
//
// One instance hangs off one PSEL of the AXI-to-APB bridge. Supports byte-lane
// writes via PSTRB, rejects unprivileged writes (PPROT[0]=0) when PROT_CHECK=1,
// and answers out-of-range or misaligned accesses with PSLVERR.
//
// Ports:
//   PCLK     in   clock, rising edge
//   PRESET   in   synchronous active-high reset
//   PSEL     in   slave select
//   PADDR    in   byte address (bits at/above ADDR_LENGTH decoded by bridge)
//   PENABLE  in   access phase
//   PWRITE   in   1=write, 0=read
//   PWDATA   in   write data
//   PSTRB    in   byte-lane write enables
//   PPROT    in   protection attributes (bit 0 = privileged)
//   PRDATA   out  read data, non-zero only in the completing cycle
//   PREADY   out  transfer complete (registered, one-cycle pulse)
//   PSLVERR  out  error response, valid with PREADY
// -----------------------------------------------------------------------------
module mem_apb_ws #(
    parameter int WIDTH_PAD     = 32,
    parameter int WIDTH_PDA     = 32,
    parameter int WIDTH_PDS     = WIDTH_PDA / 8,
    parameter int SIZE_IN_BYTES = 1024,
    parameter int ADDR_LENGTH   = 16,
    parameter int WAIT_STATES   = 0,
    parameter int PROT_CHECK    = 1
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 PSEL,
    input  logic [WIDTH_PAD-1:0] PADDR,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [WIDTH_PDA-1:0] PWDATA,
    input  logic [WIDTH_PDS-1:0] PSTRB,
    input  logic [2:0]           PPROT,
    output logic [WIDTH_PDA-1:0] PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR
);

    localparam int AW    = $clog2(SIZE_IN_BYTES);
    localparam int LSB   = $clog2(WIDTH_PDS);
    localparam int IW    = AW - LSB;
    localparam int WORDS = SIZE_IN_BYTES / WIDTH_PDS;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [WIDTH_PDA-1:0] mem [WORDS];

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 wr_q, wr_d;
    logic                 err_q, err_d;
    logic [WIDTH_PDA-1:0] prdata_q, prdata_d;
    logic                 pready_q, pready_d;
    logic                 pslverr_q, pslverr_d;

    logic                 setup;
    logic                 enter_access;
    logic [ADDR_LENGTH:0] offset_ext;
    logic                 range_err, align_err, prot_err;

    // Upper PADDR bits and PPROT[2:1] are intentionally not decoded here.
    logic                 unused_inputs;
    assign unused_inputs = ^{PADDR, PPROT};

    assign setup      = PSEL && !PENABLE;
    assign offset_ext = {1'b0, PADDR[ADDR_LENGTH-1:0]};
    assign range_err  = offset_ext >= (ADDR_LENGTH+1)'(SIZE_IN_BYTES);
    assign align_err  = PADDR[LSB-1:0] != '0;
    assign prot_err   = (PROT_CHECK != 0) && PWRITE && !PPROT[0];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wr_d         = wr_q;
        err_d        = err_q;
        enter_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    idx_d = PADDR[AW-1:LSB];
                    wr_d  = PWRITE;
                    err_d = range_err || align_err || prot_err;
                    cnt_d = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d      = ST_ACCESS;
                        enter_access = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d      = ST_ACCESS;
                        enter_access = 1'b1;
                    end
                end
            end
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Response registers are loaded on the edge that enters ACCESS so that
    // PREADY/PRDATA/PSLVERR are all valid in the same (single) ACCESS cycle.
    always_comb begin
        pready_d  = enter_access;
        pslverr_d = enter_access && err_d;
        prdata_d  = '0;
        if (enter_access && !wr_d && !err_d) begin
            prdata_d = mem[idx_d];
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Write commits on the edge closing the ACCESS cycle using the live
    // PWDATA/PSTRB, which the master holds stable for the whole transfer.
    always_ff @(posedge PCLK) begin
        if (!PRESET && state_q == ST_ACCESS && wr_q && !err_q) begin
            for (int unsigned i = 0; i < WIDTH_PDS; i++) begin
                if (PSTRB[i]) begin
                    mem[idx_q][8*i +: 8] <= PWDATA[8*i +: 8];
                end
            end
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_mem_apb_ws.sv
module tb_mem_apb_ws;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [3:0]  psel;
    logic [31:0] PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [63:0] PWDATA;
    logic [7:0]  PSTRB;
    logic [2:0]  PPROT;

    logic [31:0] rd_a, rd_b, rd_c;
    logic [63:0] rd_d;
    logic [3:0]  rdy, slverr;

    int          cur;
    logic [63:0] r_rdata;
    logic        r_ready, r_err;

    int vectors     = 0;
    int miscompares = 0;

    // instance 0: 32b WS0, 1: 32b WS2, 2: 32b WS3, 3: 64b WS0
    int lanes_of [4] = '{4, 4, 4, 8};
    int ws_of    [4] = '{0, 2, 3, 0};

    // reference model: plain byte array per instance
    logic [7:0] mdl [4][1024];

    always #5 PCLK = ~PCLK;

    mem_apb_ws #(.WIDTH_PAD(32), .WIDTH_PDA(32), .SIZE_IN_BYTES(1024),
                 .ADDR_LENGTH(16), .WAIT_STATES(0), .PROT_CHECK(1)) u_a (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PADDR(PADDR),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA[31:0]),
        .PSTRB(PSTRB[3:0]), .PPROT(PPROT), .PRDATA(rd_a), .PREADY(rdy[0]),
        .PSLVERR(slverr[0]));

    mem_apb_ws #(.WIDTH_PAD(32), .WIDTH_PDA(32), .SIZE_IN_BYTES(1024),
                 .ADDR_LENGTH(16), .WAIT_STATES(2), .PROT_CHECK(1)) u_b (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PADDR(PADDR),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA[31:0]),
        .PSTRB(PSTRB[3:0]), .PPROT(PPROT), .PRDATA(rd_b), .PREADY(rdy[1]),
        .PSLVERR(slverr[1]));

    mem_apb_ws #(.WIDTH_PAD(32), .WIDTH_PDA(32), .SIZE_IN_BYTES(1024),
                 .ADDR_LENGTH(16), .WAIT_STATES(3), .PROT_CHECK(1)) u_c (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PADDR(PADDR),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA[31:0]),
        .PSTRB(PSTRB[3:0]), .PPROT(PPROT), .PRDATA(rd_c), .PREADY(rdy[2]),
        .PSLVERR(slverr[2]));

    mem_apb_ws #(.WIDTH_PAD(32), .WIDTH_PDA(64), .SIZE_IN_BYTES(1024),
                 .ADDR_LENGTH(16), .WAIT_STATES(0), .PROT_CHECK(1)) u_d (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[3]), .PADDR(PADDR),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(rd_d), .PREADY(rdy[3]),
        .PSLVERR(slverr[3]));

    always_comb begin
        r_ready = rdy[cur[1:0]];
        r_err   = slverr[cur[1:0]];
        case (cur)
            0:       r_rdata = {32'h0, rd_a};
            1:       r_rdata = {32'h0, rd_b};
            2:       r_rdata = {32'h0, rd_c};
            default: r_rdata = rd_d;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 after the edge that
    // closes the transfer with the bus idle, so a following call starts its
    // setup phase in the very next cycle.
    task automatic xfer(input int inst, input logic wr, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [7:0] st,
                        input logic [2:0] prot, output logic [63:0] rd);
        int          lanes;
        int          base;
        int          waits;
        logic        exp_err;
        logic [63:0] exp_rd;
        lanes   = lanes_of[inst];
        exp_err = (addr[15:0] >= 16'd1024) || ((int'(addr[2:0]) % lanes) != 0)
                  || (wr && !prot[0]);
        base    = (int'(addr[9:0]) / lanes) * lanes;
        exp_rd  = '0;
        if (!wr && !exp_err)
            for (int b = 0; b < lanes; b++) exp_rd[8*b +: 8] = mdl[inst][base + b];

        cur     = inst;
        psel    = 4'(1 << inst);
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = wd;
        PSTRB   = st;
        PPROT   = prot;
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        waits = 0;
        while (!r_ready && waits < 20) begin
            waits++;
            @(posedge PCLK); #1;
        end
        chk("pready_seen", 64'(r_ready), 64'd1);
        chk("wait_cycles", 64'(waits), 64'(ws_of[inst]));
        chk("pslverr", 64'(r_err), 64'(exp_err));
        chk("prdata", r_rdata, exp_rd);
        rd = r_rdata;
        @(posedge PCLK); #1;
        psel    = '0;
        PENABLE = 1'b0;
        chk("pready_single_pulse", 64'(r_ready), 64'd0);
        if (wr && !exp_err)
            for (int b = 0; b < lanes; b++)
                if (st[b]) mdl[inst][base + b] = wd[8*b +: 8];
    endtask

    // Write to 0x0008 on the WS=2 instance, abandoned in WAIT either by
    // dropping PSEL or by pulsing PRESET.
    task automatic abort_wr(input logic use_reset);
        logic [63:0] rd;
        cur     = 1;
        psel    = 4'b0010;
        PADDR   = 32'h0000_0008;
        PWRITE  = 1'b1;
        PWDATA  = 64'h0000_0000_A5A5_5A5A;
        PSTRB   = 8'h0F;
        PPROT   = 3'b001;
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        chk("abort_wait1_pready", 64'(r_ready), 64'd0);
        @(posedge PCLK); #1;
        chk("abort_wait2_pready", 64'(r_ready), 64'd0);
        if (use_reset) PRESET = 1'b1;
        else           psel   = '0;
        @(posedge PCLK); #1;
        chk("abort_after_pready", 64'(r_ready), 64'd0);
        chk("abort_after_prdata", r_rdata, 64'd0);
        chk("abort_after_pslverr", 64'(r_err), 64'd0);
        PRESET  = 1'b0;
        psel    = '0;
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
        chk("abort_late_pready", 64'(r_ready), 64'd0);
        xfer(1, 1'b0, 32'h0000_0008, '0, '0, 3'b001, rd);
    endtask

    initial begin
        logic [63:0] rd, wd;
        logic [31:0] rnd;
        logic [15:0] off;
        logic [15:0] lmask;
        int          inst;

        cur     = 0;
        PRESET  = 1'b1;
        psel    = '0;
        PADDR   = '0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PWDATA  = '0;
        PSTRB   = '0;
        PPROT   = '0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset_pready", 64'(rdy), 64'd0);
        chk("reset_pslverr", 64'(slverr), 64'd0);
        chk("reset_prdata_a", 64'(rd_a), 64'd0);
        chk("reset_prdata_b", 64'(rd_b), 64'd0);
        chk("reset_prdata_c", 64'(rd_c), 64'd0);
        chk("reset_prdata_d", rd_d, 64'd0);
        PRESET = 1'b0;

        // streaming fill then full readback on every instance, no idle cycles
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < 1024 / lanes_of[i]; w++) begin
                wd = {$urandom, $urandom};
                xfer(i, 1'b1, 32'(w * lanes_of[i]), wd, 8'hFF, 3'b001, rd);
            end
            for (int w = 0; w < 1024 / lanes_of[i]; w++)
                xfer(i, 1'b0, 32'(w * lanes_of[i]), '0, '0, 3'b001, rd);
        end

        // zero-wait write then read
        xfer(0, 1'b1, 32'h0000_0010, 64'hDEAD_BEEF, 8'h0F, 3'b001, rd);
        xfer(0, 1'b0, 32'h0000_0010, '0, '0, 3'b001, rd);
        chk("ws0_readback", rd, 64'hDEAD_BEEF);

        // three wait states
        xfer(2, 1'b0, 32'h0000_0020, '0, '0, 3'b001, rd);

        // byte-lane write
        xfer(0, 1'b1, 32'h0000_0004, 64'hFFFF_FFFF, 8'h0F, 3'b001, rd);
        xfer(0, 1'b1, 32'h0000_0004, 64'h00AA_0000, 8'h04, 3'b001, rd);
        xfer(0, 1'b0, 32'h0000_0004, '0, '0, 3'b001, rd);
        chk("strobe_merge", rd, 64'hFFAA_FFFF);
        xfer(0, 1'b1, 32'h0000_0004, 64'h1111_1111, 8'h00, 3'b001, rd);
        xfer(0, 1'b0, 32'h0000_0004, '0, '0, 3'b001, rd);
        chk("strobe_zero_noop", rd, 64'hFFAA_FFFF);

        // error responses
        xfer(0, 1'b0, 32'h0000_0400, '0, '0, 3'b001, rd);
        xfer(0, 1'b0, 32'h0000_0002, '0, '0, 3'b001, rd);
        xfer(0, 1'b1, 32'h0000_0010, 64'h0, 8'h0F, 3'b000, rd);
        xfer(0, 1'b0, 32'h0000_0010, '0, '0, 3'b001, rd);
        chk("prot_reject_readback", rd, 64'hDEAD_BEEF);
        xfer(0, 1'b0, 32'hFFFF_03FC, '0, '0, 3'b000, rd);

        // aborts in WAIT
        abort_wr(1'b0);
        abort_wr(1'b1);

        // PSEL+PENABLE seen in IDLE is ignored
        cur     = 0;
        psel    = 4'b0001;
        PADDR   = 32'h0000_0010;
        PWRITE  = 1'b1;
        PWDATA  = 64'h0BAD_0BAD;
        PSTRB   = 8'h0F;
        PPROT   = 3'b001;
        PENABLE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge PCLK); #1;
            chk("violation_pready", 64'(r_ready), 64'd0);
        end
        psel    = '0;
        PENABLE = 1'b0;
        xfer(0, 1'b0, 32'h0000_0010, '0, '0, 3'b001, rd);
        chk("violation_readback", rd, 64'hDEAD_BEEF);

        // randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            inst  = $urandom_range(0, 3);
            lmask = 16'(lanes_of[inst] - 1);
            rnd   = $urandom;
            case ($urandom_range(0, 9))
                0:       off = 16'($urandom_range(1024, 65535)) & ~lmask;
                1:       off = 16'($urandom_range(0, 1023)) | 16'd1;
                default: off = 16'($urandom_range(0, 1023)) & ~lmask;
            endcase
            wd = {$urandom, $urandom};
            xfer(inst, 1'($urandom_range(0, 1)), {rnd[31:16], off}, wd,
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 7) == 0) ? 3'b000 : (3'($urandom_range(0, 7)) | 3'b001),
                 rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
